// File: rtl/imm_encode.sv
// Immediate encoder: packs a 32-bit immediate into an instruction word's immediate fields.
// Two-stage valid/ready pipeline (legality check, field merge) with a saturating reject counter.
module imm_encode #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_type,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_base,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [2:0] TYPE_RT = 3'd0;
    localparam logic [2:0] TYPE_IT = 3'd1;
    localparam logic [2:0] TYPE_ST = 3'd2;
    localparam logic [2:0] TYPE_BT = 3'd3;
    localparam logic [2:0] TYPE_JT = 3'd4;
    localparam logic [2:0] TYPE_UT = 3'd5;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // an offered output (o_valid, o_instr, o_err) stays frozen until i_ready accepts it.

    // True when imm[31:k] are all copies of the sign bit.
    function automatic logic sext_ok(input logic [31:0] imm, input int k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (i >= k && imm[i] != imm[31]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic imm_legal(input logic [2:0] t, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (t)
            TYPE_RT: ok = (imm[4:0] == 5'd0) && sext_ok(imm, 11);
            TYPE_IT: ok = sext_ok(imm, 11);
            TYPE_ST: ok = sext_ok(imm, 11);
            TYPE_BT: ok = !imm[0] && sext_ok(imm, 12);
            TYPE_JT: ok = !imm[0] && sext_ok(imm, 20);
            TYPE_UT: ok = (imm[11:0] == 12'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Illegal immediates are still merged from their truncated bits.
    function automatic logic [31:0] imm_merge(input logic [2:0] t, input logic [31:0] imm,
                                              input logic [31:0] base);
        logic [31:0] r;
        r = base;
        case (t)
            TYPE_RT: r[31:25] = imm[11:5];
            TYPE_IT: r[31:20] = imm[11:0];
            TYPE_ST: begin
                r[31:25] = imm[11:5];
                r[11:7]  = imm[4:0];
            end
            TYPE_BT: begin
                r[31]    = imm[12];
                r[7]     = imm[11];
                r[30:25] = imm[10:5];
                r[11:8]  = imm[4:1];
            end
            TYPE_JT: begin
                r[31]    = imm[20];
                r[30:21] = imm[10:1];
                r[20]    = imm[11];
                r[19:12] = imm[19:12];
            end
            TYPE_UT: r[31:12] = imm[31:12];
            default: r = base;
        endcase
        return r;
    endfunction

    logic        s1_valid;
    logic [2:0]  s1_type;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;
    logic        s1_err;
    logic [31:0] s1_instr;
    logic        s2_load;
    logic        out_fire;

    assign s2_load  = !o_valid || i_ready;
    assign o_ready  = !s1_valid || s2_load;
    assign out_fire = o_valid && i_ready;

    assign s1_err   = !imm_legal(s1_type, s1_imm);
    assign s1_instr = imm_merge(s1_type, s1_imm, s1_base);

    // Stage 1: capture request; legality is evaluated on these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_type  <= 3'd0;
            s1_imm   <= 32'd0;
            s1_base  <= 32'd0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_type <= i_type;
                s1_imm  <= i_imm;
                s1_base <= i_base;
            end
        end
    end

    // Stage 2: merged word and error flag, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_instr <= 32'd0;
            o_err   <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_instr <= s1_instr;
                o_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err_cnt <= '0;
        end else if (out_fire && o_err && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: scoreboard queue filled by the driver, popped by a negedge monitor,
// with a behavioural range/alignment model and a decode-side round-trip check.
module tb_imm_encode;

    localparam logic [2:0] RT = 3'd0, IT = 3'd1, ST = 3'd2, BT = 3'd3, JT = 3'd4, UT = 3'd5;
    localparam int EXP_W = 68;  // {type, imm, instr, err}

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [2:0]  i_type;
    logic [31:0] i_imm;
    logic [31:0] i_base;
    logic        i_ready;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_instr;
    logic [7:0]  o_err_cnt;
    logic        sat_ready, sat_valid, sat_err;
    logic [31:0] sat_instr;
    logic [1:0]  sat_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cnt_model = 0;
    int sat_model = 0;
    int accept_cnt = 0;
    int rdy_mode = 0;  // 0: always ready, 1: stalled, 2: random

    imm_encode #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_type(i_type),
        .i_imm(i_imm), .i_base(i_base), .o_valid(o_valid), .i_ready(i_ready),
        .o_instr(o_instr), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    imm_encode #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(sat_ready), .i_type(i_type),
        .i_imm(i_imm), .i_base(i_base), .o_valid(sat_valid), .i_ready(i_ready),
        .o_instr(sat_instr), .o_err(sat_err), .o_err_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Legality from value ranges and alignment.
    function automatic logic ref_legal(input logic [2:0] t, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (t)
            RT:      return (s % 32 == 0) && s >= -2048 && s <= 2047;
            IT, ST:  return s >= -2048 && s <= 2047;
            BT:      return (s % 2 == 0) && s >= -4096 && s <= 4095;
            JT:      return (s % 2 == 0) && s >= -(1 << 20) && s <= (1 << 20) - 1;
            UT:      return (s % 4096 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [2:0] t, input logic [31:0] imm,
                                              input logic [31:0] base);
        logic [31:0] r;
        r = base;
        case (t)
            RT: r[31:25] = imm[11:5];
            IT: r[31:20] = imm[11:0];
            ST: begin r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; end
            BT: begin r[31] = imm[12]; r[7] = imm[11]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; end
            JT: begin r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12]; end
            UT: r[31:12] = imm[31:12];
            default: r = base;
        endcase
        return r;
    endfunction

    // Decode-side extraction used for the round-trip property.
    function automatic int ref_decode(input logic [2:0] t, input logic [31:0] w);
        logic [11:0] f12;
        logic [12:0] f13;
        logic [20:0] f21;
        case (t)
            RT: begin f12 = {w[31:25], 5'd0}; return int'($signed(f12)); end
            IT: begin f12 = w[31:20]; return int'($signed(f12)); end
            ST: begin f12 = {w[31:25], w[11:7]}; return int'($signed(f12)); end
            BT: begin f13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'($signed(f13)); end
            JT: begin f21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; return int'($signed(f21)); end
            UT: return int'({w[31:12], 12'd0});
            default: return 0;
        endcase
    endfunction

    task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] exp_instr, input logic exp_err);
        int guard;
        guard = 0;
        i_valid = 1'b1;
        i_type  = t;
        i_imm   = imm;
        i_base  = base;
        @(negedge clk);
        while (!o_ready) begin
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: o_ready stuck at 0 for %0d cycles", guard);
                break;
            end
            @(negedge clk);
        end
        if (o_ready) begin
            exp_q.push_back({t, imm, exp_instr, exp_err});
            accept_cnt++;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_model(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
        send(t, imm, base, ref_merge(t, imm, base), !ref_legal(t, imm));
    endtask

    function automatic logic [31:0] rand_legal(input logic [2:0] t);
        case (t)
            RT:      return 32'((int'($urandom_range(0, 127)) - 64) * 32);
            IT, ST:  return 32'(int'($urandom_range(0, 4095)) - 2048);
            BT:      return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            JT:      return 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
            default: return $urandom & 32'hFFFF_F000;
        endcase
    endfunction

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'b0;
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: every offered output must equal the queue head until it is taken.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {31'd0, o_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                check("instr", o_instr, e[32:1]);
                check("err", {31'd0, o_err}, {31'd0, e[0]});
                if (!e[0]) check("roundtrip", 32'(ref_decode(e[67:65], o_instr)), e[64:33]);
                if (i_ready) begin
                    check("err_cnt", {24'd0, o_err_cnt}, 32'(cnt_model));
                    check("sat_cnt", {30'd0, sat_cnt}, 32'(sat_model));
                    if (e[0]) begin
                        if (cnt_model < 255) cnt_model++;
                        if (sat_model < 3) sat_model++;
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0] t;
        int guard;
        rst = 1'b1;
        i_valid = 1'b0;
        i_type = 3'd0;
        i_imm = 32'd0;
        i_base = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_instr", o_instr, 32'd0);
        check("reset_err", {31'd0, o_err}, 32'd0);
        check("reset_cnt", {24'd0, o_err_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Saturation of the 2-bit counter: five rejected immediates.
        for (int i = 0; i < 5; i++) send(UT, 32'h0000_0001 + i, 32'h0000_0037, 32'h0000_0037, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("sat_final", {30'd0, sat_cnt}, 32'd3);
        check("cnt_after5", {24'd0, o_err_cnt}, 32'd5);

        // Directed vectors, including two-cycle latency.
        send(IT, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, o_valid}, 32'd1);
        send(BT, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        send(BT, 32'h0000_1001, 32'h0000_0063, ref_merge(BT, 32'h0000_1001, 32'h0000_0063), 1'b1);
        send(JT, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
        send(UT, 32'h1234_5678, 32'h0000_0037, 32'h1234_5037, 1'b1);
        send(3'd6, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: four back-to-back requests against a stalled consumer.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        accept_cnt = 0;
        fork
            begin
                send_model(ST, 32'hFFFF_F9A5, 32'h0000_0023);
                send_model(IT, 32'h0000_07FF, 32'h0000_0013);
                send_model(RT, 32'h0000_0140, 32'h0000_5013);
                send_model(BT, 32'hFFFF_F000, 32'h0000_0063);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("bp_accepts", 32'(accept_cnt), 32'd2);
                check("bp_ready_low", {31'd0, o_ready}, 32'd0);
                rdy_mode = 0;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with both stages full.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send_model(IT, 32'd5, 32'h0000_0013);
        send_model(IT, 32'd6, 32'h0000_0013);
        #2;
        check("full_before_reset", {31'd0, o_valid}, 32'd1);
        rst = 1'b1;
        exp_q.delete();
        cnt_model = 0;
        sat_model = 0;
        #1;
        check("async_valid", {31'd0, o_valid}, 32'd0);
        check("async_cnt", {24'd0, o_err_cnt}, 32'd0);
        check("async_sat_cnt", {30'd0, sat_cnt}, 32'd0);
        check("async_instr", o_instr, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_output", {31'd0, o_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Random legal round-trip traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            t = 3'($urandom_range(0, 5));
            send_model(t, rand_legal(t), $urandom);
        end
        // Arbitrary immediates and type codes, mostly rejected; pushes the 8-bit counter past saturation.
        for (int i = 0; i < 400; i++) begin
            send_model(3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        rdy_mode = 0;
        guard = 0;
        while ((exp_q.size() != 0 || o_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("final_cnt", {24'd0, o_err_cnt}, 32'(cnt_model));
        check("final_sat_cnt", {30'd0, sat_cnt}, 32'(sat_model));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
